// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the set-associative data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMiss,
    StWriteback,
    StRefill,
    StRefillOk
  } state_e;

  // Widest tag possible with SETS >= 2 and LINE_WORDS >= 2 (32 - 1 - 3).
  localparam int unsigned TagMaxW = 28;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TagMaxW-1:0] tag;
  } tag_entry_t;

  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words * 4);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned sets, input int unsigned line_words);
    return 32 - idx_w(sets) - off_w(line_words);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: per-set tag entry and line storage, combinational read, posedge write.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int unsigned Sets     = 16,
  parameter int unsigned IdxW     = 4,
  parameter int unsigned LineBits = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IdxW-1:0]     idx_i,
  output tag_entry_t          entry_o,
  output logic [LineBits-1:0] line_o,
  input  logic                we_i,
  input  tag_entry_t          entry_i,
  input  logic [LineBits-1:0] line_i
);

  logic [Sets-1:0]     valid_q;
  logic [Sets-1:0]     dirty_q;
  logic [TagMaxW-1:0]  tag_q  [Sets];
  logic [LineBits-1:0] data_q [Sets];

  assign entry_o = '{valid: valid_q[idx_i], dirty: dirty_q[idx_i], tag: tag_q[idx_i]};
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= entry_i.valid;
      dirty_q[idx_i] <= entry_i.dirty;
    end
  end

  // Tags and line data are only meaningful under valid, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= entry_i.tag;
      data_q[idx_i] <= line_i;
    end
  end

endmodule

// File: rtl/dcache_sa.sv
// N-way set-associative write-back, write-allocate L1 data cache with round-robin
// replacement and saturating hit/miss counters.
module dcache_sa
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             p1_addr_i,
  input  logic [31:0]             p1_data_i,
  input  logic                    p1_MemRead_i,
  input  logic                    p1_MemWrite_i,
  output logic [31:0]             p1_data_o,
  output logic                    p1_stall_o,
  output logic [31:0]             mem_addr_o,
  output logic [32*LINE_WORDS-1:0] mem_data_o,
  input  logic [32*LINE_WORDS-1:0] mem_data_i,
  output logic                    mem_enable_o,
  output logic                    mem_write_o,
  input  logic                    mem_ack_i,
  output logic [CNT_W-1:0]        hit_cnt_o,
  output logic [CNT_W-1:0]        miss_cnt_o
);

  localparam int unsigned LineBits = 32 * LINE_WORDS;
  localparam int unsigned OffW     = off_w(LINE_WORDS);
  localparam int unsigned IdxW     = idx_w(SETS);
  localparam int unsigned TagW     = tag_w(SETS, LINE_WORDS);
  localparam int unsigned WordW    = OffW - 2;
  localparam int unsigned WayW     = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TagW-1:0]  p1_tag;
  logic [IdxW-1:0]  p1_idx;
  logic [WordW-1:0] p1_word;
  logic [31:0]      p1_line_addr;
  logic             p1_req;
  logic             unused_addr;

  assign p1_tag       = p1_addr_i[31 -: TagW];
  assign p1_idx       = p1_addr_i[OffW +: IdxW];
  assign p1_word      = p1_addr_i[2 +: WordW];
  assign p1_line_addr = {p1_tag, p1_idx, {OffW{1'b0}}};
  assign p1_req       = p1_MemRead_i | p1_MemWrite_i;
  assign unused_addr  = ^p1_addr_i[1:0];

  state_e            state_q, state_d;
  logic [WayW-1:0]   victim_q, victim_d, victim_sel, hit_way;
  logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              replay_q, replay_d;
  logic              miss_inc;
  logic [WayW-1:0]   rr_q [SETS];
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

  tag_entry_t          entry [WAYS];
  logic [LineBits-1:0] line  [WAYS];
  logic [WAYS-1:0]     way_match, way_we;
  tag_entry_t          wr_entry, vic_entry;
  logic [LineBits-1:0] wr_line, hit_line;
  logic                hit, refill_we;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way #(
      .Sets     (SETS),
      .IdxW     (IdxW),
      .LineBits (LineBits)
    ) u_way (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .idx_i   (p1_idx),
      .entry_o (entry[w]),
      .line_o  (line[w]),
      .we_i    (way_we[w]),
      .entry_i (wr_entry),
      .line_i  (wr_line)
    );
    assign way_match[w] = entry[w].valid && (entry[w].tag == TagMaxW'(p1_tag));
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_match[w]) hit_way = WayW'(w);
    end
  end

  // Lookups only count in Idle so the refill-ok cycle still stalls before the replay.
  assign hit        = p1_req && (state_q == StIdle) && (|way_match);
  assign p1_stall_o = p1_req && !hit;
  assign hit_line   = line[hit_way];
  assign p1_data_o  = hit ? hit_line[{p1_word, 5'b0} +: 32] : 32'h0;

  always_comb begin
    victim_sel = rr_q[p1_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!entry[w].valid) victim_sel = WayW'(w);
    end
  end

  assign vic_entry  = entry[victim_q];
  assign mem_data_o = line[victim_q];
  assign refill_we  = (state_q == StRefill) && mem_ack_i;

  always_comb begin
    wr_line                         = hit_line;
    wr_line[{p1_word, 5'b0} +: 32]  = p1_data_i;
    wr_entry                        = '{valid: 1'b1, dirty: 1'b1, tag: TagMaxW'(p1_tag)};
    way_we                          = '0;
    if (refill_we) begin
      wr_line          = mem_data_i;
      wr_entry.dirty   = 1'b0;
      way_we[victim_q] = 1'b1;
    end else if (hit && p1_MemWrite_i) begin
      way_we[hit_way] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    mem_en_d   = mem_en_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    replay_d   = 1'b0;
    miss_inc   = 1'b0;
    case (state_q)
      StIdle: begin
        if (p1_req && !hit) begin
          victim_d = victim_sel;
          miss_inc = 1'b1;
          state_d  = StMiss;
        end
      end
      StMiss: begin
        mem_en_d = 1'b1;
        if (vic_entry.valid && vic_entry.dirty) begin
          mem_wr_d   = 1'b1;
          mem_addr_d = {vic_entry.tag[TagW-1:0], p1_idx, {OffW{1'b0}}};
          state_d    = StWriteback;
        end else begin
          mem_wr_d   = 1'b0;
          mem_addr_d = p1_line_addr;
          state_d    = StRefill;
        end
      end
      StWriteback: begin
        if (mem_ack_i) begin
          mem_wr_d   = 1'b0;
          mem_addr_d = p1_line_addr;
          state_d    = StRefill;
        end
      end
      StRefill: begin
        if (mem_ack_i) begin
          mem_en_d = 1'b0;
          state_d  = StRefillOk;
        end
      end
      StRefillOk: begin
        replay_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      victim_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      replay_q   <= replay_d;
      if (refill_we) begin
        rr_q[p1_idx] <= (rr_q[p1_idx] == WayW'(WAYS - 1)) ? '0 : rr_q[p1_idx] + WayW'(1);
      end
      if (hit && !replay_q && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_dcache_sa.sv
// Self-checking bench for dcache_sa: memory model, expected-transaction scoreboard,
// reference word memory for read data.
module tb_dcache_sa;

  localparam int unsigned WAYS  = 2;
  localparam int unsigned SETS  = 16;
  localparam int unsigned LW    = 8;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned LB    = 32 * LW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [31:0]   p1_addr_i = '0, p1_data_i = '0;
  logic          p1_MemRead_i = 1'b0, p1_MemWrite_i = 1'b0;
  logic [31:0]   p1_data_o;
  logic          p1_stall_o;
  logic [31:0]   mem_addr_o;
  logic [LB-1:0] mem_data_o;
  logic [LB-1:0] mem_data_i = '0;
  logic          mem_enable_o, mem_write_o;
  logic          mem_ack_i = 1'b0;
  logic [CNT_W-1:0] hit_cnt_o, miss_cnt_o;

  always #5 clk_i = ~clk_i;

  dcache_sa #(
    .WAYS       (WAYS),
    .SETS       (SETS),
    .LINE_WORDS (LW),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_ack_i     (mem_ack_i),
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] w1;
  } txn_t;

  txn_t          exp_txn_q [$];
  logic [31:0]   exp_rd_q  [$];
  logic [LB-1:0] bmem      [logic [31:0]];
  logic [31:0]   ref_mem   [logic [31:0]];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            last_cyc;
  bit            last_saw_wr;

  function automatic logic [LB-1:0] pat_line(input logic [31:0] la);
    logic [LB-1:0] l;
    for (int i = 0; i < LW; i++) l[i*32 +: 32] = 32'hA000_0000 + ((la - 32'h40) << 8) + 32'(i);
    return l;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [LB-1:0] l;
    if (ref_mem.exists(a)) return ref_mem[a];
    l = pat_line({a[31:5], 5'b0});
    return l[{a[4:2], 5'b0} +: 32];
  endfunction

  // Protocol monitors: single matching way, CPU holds its request while stalled.
  logic        prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  always @(posedge clk_i) begin
    if (!$onehot0(dut.way_match)) begin
      n_fail++;
      $display("FAIL onehot: way_match=%b, required at most one bit set", dut.way_match);
    end
    if (prev_stall && (p1_addr_i !== prev_addr || p1_data_i !== prev_data ||
                       p1_MemRead_i !== prev_rd || p1_MemWrite_i !== prev_wr)) begin
      n_fail++;
      $display("FAIL hold: request changed mid-miss addr=%h, required %h", p1_addr_i, prev_addr);
    end
    prev_stall <= p1_stall_o && !rst_i;
    prev_addr  <= p1_addr_i;
    prev_data  <= p1_data_i;
    prev_rd    <= p1_MemRead_i;
    prev_wr    <= p1_MemWrite_i;
  end

  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int dly, input string name);
    int          cyc, cnt;
    bit          busy;
    logic        cur_wr;
    logic [31:0] cur_addr, exp;
    txn_t        t;
    if (wr) ref_mem[addr] = wdata;
    else exp_rd_q.push_back(ref_rd(addr));
    @(negedge clk_i);
    p1_addr_i = addr; p1_data_i = wdata; p1_MemRead_i = !wr; p1_MemWrite_i = wr;
    cyc = 0; cnt = 0; busy = 0; cur_wr = 0; cur_addr = '0; last_saw_wr = 0;
    forever begin
      #1;
      mem_ack_i = 1'b0;
      if (!p1_stall_o) break;
      if (cyc >= 200) begin
        n_cmp++; n_fail++;
        $display("FAIL %s timeout: stall high after %0d cycles, required release", name, cyc);
        break;
      end
      if (mem_enable_o) begin
        if (mem_write_o) last_saw_wr = 1;
        n_cmp++;
        if (!busy) begin
          busy = 1; cnt = 0; cur_wr = mem_write_o; cur_addr = mem_addr_o;
          if (exp_txn_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s txn: got wr=%0b addr=%h, required no transaction", name, cur_wr,
                     cur_addr);
          end else begin
            t = exp_txn_q.pop_front();
            if (cur_wr !== t.wr || cur_addr !== t.addr || (t.wr && mem_data_o[63:32] !== t.w1)) begin
              n_fail++;
              $display("FAIL %s txn: got wr=%0b addr=%h w1=%h, required wr=%0b addr=%h w1=%h",
                       name, cur_wr, cur_addr, mem_data_o[63:32], t.wr, t.addr, t.w1);
            end
          end
        end else if (mem_write_o !== cur_wr || mem_addr_o !== cur_addr) begin
          n_fail++;
          $display("FAIL %s stable: got wr=%0b addr=%h, required wr=%0b addr=%h", name,
                   mem_write_o, mem_addr_o, cur_wr, cur_addr);
        end
        if (cnt == dly) begin
          mem_ack_i = 1'b1; busy = 0;
          if (cur_wr) bmem[cur_addr] = mem_data_o;
          else mem_data_i = bmem.exists(cur_addr) ? bmem[cur_addr] : pat_line(cur_addr);
        end else cnt++;
      end
      @(negedge clk_i);
      cyc++;
    end
    last_cyc = cyc;
    if (!wr) begin
      exp = exp_rd_q.pop_front();
      n_cmp++;
      if (p1_data_o !== exp) begin
        n_fail++;
        $display("FAIL %s data: got %h, required %h", name, p1_data_o, exp);
      end
    end
    n_cmp++;
    if (exp_txn_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s txn_left: got %0d pending, required 0", name, exp_txn_q.size());
      exp_txn_q.delete();
    end
    @(negedge clk_i);
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  task automatic chk_cyc(input string name, input int req);
    n_cmp++;
    if (last_cyc != req) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d, required %0d", name, last_cyc, req);
    end
  endtask

  task automatic chk_cnt(input string name, input int hits, input int misses);
    n_cmp++;
    if (hit_cnt_o !== CNT_W'(hits) || miss_cnt_o !== CNT_W'(misses)) begin
      n_fail++;
      $display("FAIL %s counters: got hit=%0d miss=%0d, required hit=%0d miss=%0d", name,
               hit_cnt_o, miss_cnt_o, hits, misses);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset mem: got en=%0b wr=%0b addr=%h, required 0 0 0", mem_enable_o,
               mem_write_o, mem_addr_o);
    end
    n_cmp++;
    if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset p1: got stall=%0b data=%h, required 0 0", p1_stall_o, p1_data_o);
    end
    chk_cnt("reset", 0, 0);
  endtask

  task automatic test_cold_read;
    exp_txn_q.push_back('{wr: 1'b0, addr: 32'h40, w1: 32'h0});
    do_access(0, 32'h40, 32'h0, 1, "cold_read");
    chk_cyc("cold_read", 5);
    chk_cnt("cold_read", 0, 1);
  endtask

  task automatic test_write_hit;
    do_access(1, 32'h44, 32'hDEAD_BEEF, 0, "write_hit");
    chk_cyc("write_hit", 0);
    do_access(0, 32'h44, 32'h0, 0, "read_back");
    chk_cyc("read_back", 0);
    chk_cnt("write_hit", 2, 1);
  endtask

  task automatic test_conflict;
    exp_txn_q.push_back('{wr: 1'b0, addr: 32'h240, w1: 32'h0});
    do_access(0, 32'h240, 32'h0, 2, "fill_240");
    chk_cyc("fill_240", 6);
    exp_txn_q.push_back('{wr: 1'b1, addr: 32'h40, w1: 32'hDEAD_BEEF});
    exp_txn_q.push_back('{wr: 1'b0, addr: 32'h440, w1: 32'h0});
    do_access(0, 32'h448, 32'h0, 1, "evict_dirty");
    chk_cyc("evict_dirty", 7);
    chk_cnt("conflict", 2, 3);
  endtask

  task automatic test_clean_evict;
    // Round-robin now points at way 1 (0x240, clean).
    exp_txn_q.push_back('{wr: 1'b0, addr: 32'h640, w1: 32'h0});
    do_access(0, 32'h640, 32'h0, 0, "evict_clean");
    chk_cyc("evict_clean", 4);
    n_cmp++;
    if (last_saw_wr) begin
      n_fail++;
      $display("FAIL evict_clean write: got mem_write_o=1, required 0");
    end
    do_access(0, 32'h440, 32'h0, 0, "keep_440");
    chk_cyc("keep_440", 0);
    do_access(0, 32'h65C, 32'h0, 0, "keep_640");
    chk_cyc("keep_640", 0);
    exp_txn_q.push_back('{wr: 1'b0, addr: 32'h40, w1: 32'h0});
    do_access(0, 32'h44, 32'h0, 3, "reload_40");
    chk_cyc("reload_40", 7);
    chk_cnt("clean_evict", 4, 5);
  endtask

  task automatic test_ack_delays;
    int          dl [3] = '{0, 1, 7};
    logic [31:0] ad [3] = '{32'h1000, 32'h1020, 32'h1060};
    for (int k = 0; k < 3; k++) begin
      exp_txn_q.push_back('{wr: 1'b0, addr: ad[k], w1: 32'h0});
      do_access(0, ad[k] + 32'h8, 32'h0, dl[k], "ack_delay");
      chk_cyc("ack_delay", 4 + dl[k]);
    end
    do_access(1, 32'h1004, 32'h5555_AAAA, 0, "dirty_1000");
    exp_txn_q.push_back('{wr: 1'b0, addr: 32'h1200, w1: 32'h0});
    do_access(0, 32'h1200, 32'h0, 0, "fill_1200");
    exp_txn_q.push_back('{wr: 1'b1, addr: 32'h1000, w1: 32'h5555_AAAA});
    exp_txn_q.push_back('{wr: 1'b0, addr: 32'h1400, w1: 32'h0});
    do_access(0, 32'h1404, 32'h0, 7, "wb_delay7");
    chk_cyc("wb_delay7", 19);
    chk_cnt("ack_delays", 5, 10);
  endtask

  task automatic test_reset_mid_miss;
    bit found = 0;
    do_access(1, 32'h644, 32'h0BAD_F00D, 0, "dirty_640");
    @(negedge clk_i);
    p1_addr_i = 32'h240; p1_data_i = '0; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mem_enable_o && mem_write_o) begin
        found = 1;
        break;
      end
      @(negedge clk_i);
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL mid_reset writeback: got no write-back request, required one");
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset mem: got en=%0b wr=%0b addr=%h, required 0 0 0", mem_enable_o,
               mem_write_o, mem_addr_o);
    end
    chk_cnt("mid_reset", 0, 0);
    rst_i = 1'b0; p1_MemRead_i = 1'b0;
    ref_mem.delete(32'h644);
    exp_txn_q.push_back('{wr: 1'b0, addr: 32'h40, w1: 32'h0});
    do_access(0, 32'h44, 32'h0, 2, "reread_44");
    chk_cyc("reread_44", 6);
    chk_cnt("reread_44", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_conflict();
    test_clean_evict();
    test_ack_delays();
    test_reset_mid_miss();
    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
